lock_mem_requester: RTL and testbench
=====================================

Name: lock_mem_requester

Overview:
- Per-core requester side of the shared-memory lock protocol: accepts one store or atomic add command from a core, raises need_lock, waits for the arbiter to grant, performs the guarded memory access, then drops need_lock.
- One instance sits between each tiny_risc_v core and its port of the two-port global memory.
- The arbiter drives this block's stall_in (its lock bit for this core).
- Grant means stall_in low while need_lock is held.

Parameters:
- AW, 6, memory address width.
- DW, 32, data width.
- RD_LAT, 1, cycles from address presented (wren low) to valid mem_q; legal 1..3.
- TIMEOUT, 0, max cycles waiting for grant before abort; 0 = wait forever.
- TW, 8, width of the wait counter; TIMEOUT must be < 2^TW.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-low.
- cmd_valid  input  1  core presents a command.
- cmd_ready  output  1  block can accept a command (high only in IDLE).
- cmd_addr  input  AW  target word address.
- cmd_data  input  DW  store data, or addend when cmd_rmw is high.
- cmd_rmw  input  1  1 = atomic mem[addr] += cmd_data; 0 = plain store.
- done  output  1  one-cycle pulse when the access has completed and the lock has been released.
- err  output  1  one-cycle pulse on timeout abort; no memory write occurs.
- old_val  output  DW  value read before the add (rmw only); held until the next rmw.
- need_lock  output  1  lock request to the arbiter.
- stall_in  input  1  arbiter lock bit for this core; 1 = denied or stalled.
- mem_addr  output  AW  memory port address.
- mem_data  output  DW  memory port write data.
- mem_wren  output  1  memory port write enable.
- mem_q  input  DW  memory port read data.

Behaviour:
- Reset (async, rst=0), from any state including mid-access:
  - State goes to IDLE.
  - cmd_ready=1 once out of reset.
  - need_lock=0, mem_wren=0, done=0, err=0.
  - mem_addr=0, mem_data=0, old_val=0, wait counter=0.
- FSM states: IDLE, REQ, CHECK, READ, WRITE, RELEASE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch addr/data/rmw and go to REQ.
- REQ:
  - need_lock=1.
  - Fixed one-cycle wait, because the arbiter samples need_lock on a register. Go to CHECK.
- CHECK:
  - need_lock stays 1.
  - If stall_in=0: granted. Go to READ if rmw, otherwise WRITE.
  - If stall_in=1: increment the wait counter and stay.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT: go to RELEASE with the abort flag set.
- READ:
  - mem_addr=addr, mem_wren=0.
  - Hold for RD_LAT cycles.
  - On the last cycle, capture mem_q into old_val and compute the sum = mem_q + data.
  - Sum is mod 2^DW; carry discarded.
  - Then go to WRITE.
- WRITE:
  - Exactly one cycle: mem_addr=addr, mem_data=(rmw ? sum : data), mem_wren=1.
  - Then go to RELEASE.
- RELEASE:
  - need_lock=0, mem_wren=0.
  - Pulse done, or err if aborted.
  - Clear the wait counter and return to IDLE.
- need_lock stays high continuously from REQ until RELEASE; no glitch low during a granted access.
- If stall_in rises after the grant (arbiter misbehaviour), ignore it; the access completes.
- cmd_valid while not in IDLE is ignored, because cmd_ready=0. A new command can be accepted the cycle after RELEASE.
- Minimum latency, cmd accept to done:
  - Store, granted first try: 4 cycles (REQ, CHECK, WRITE, RELEASE).
  - rmw: 4+RD_LAT cycles.
- mem_wren is never high outside WRITE.

Optional Feature:
- Macro: LOCK_STATS_EN.
- When defined, adds three outputs:
  - stat_grants (16b): count of completed accesses.
  - stat_wait_cycles (16b): total CHECK cycles with stall_in=1.
  - stat_timeouts (8b): count of aborts.
- All three are saturating, reset to 0 by rst, and otherwise free-running.
- When not defined, these ports and their logic are absent; behaviour is otherwise identical.

Test Plan:
- Store, no contention: cmd addr=5, data=0xDEADBEEF, rmw=0, stall_in=0 -> need_lock high 3 cycles; mem_wren for one cycle with addr 5 / data 0xDEADBEEF; done pulses 4 cycles after accept.
- Atomic add: mem[3]=0x10, cmd addr=3, data=0x5, rmw=1, RD_LAT=1 -> old_val=0x10, write 0x15, done at cycle 5.
- Contention: stall_in=1 for 6 cycles in CHECK, then 0 -> need_lock held continuously, no mem_wren before grant, write then done; stats (if enabled) stat_wait_cycles=6, stat_grants=1.
- Timeout: TIMEOUT=4, stall_in held 1 -> err pulse after 4 wait cycles, mem_wren never asserted, need_lock drops, cmd_ready returns 1.
- Reset mid-rmw: assert rst=0 during READ -> need_lock, mem_wren, done deassert immediately; after release, IDLE with cmd_ready=1 and no write performed.
- Overflow and back-to-back: mem[0]=0xFFFFFFFF, rmw add 1 -> write 0x0; a second cmd held valid is accepted the cycle after done.

Source files
------------

// File: rtl/lock_mem_requester.sv
// lock_mem_requester: per-core requester that takes the shared-memory lock, does a guarded store or atomic add, then releases it.
// Define LOCK_STATS_EN to add saturating grant/wait/timeout counters.
module lock_mem_requester #(
  parameter int AW      = 6,
  parameter int DW      = 32,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 0,
  parameter int TW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_data,
  input  logic          cmd_rmw,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] old_val,
  output logic          need_lock,
  input  logic          stall_in,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_q
`ifdef LOCK_STATS_EN
  ,
  output logic [15:0]   stat_grants,
  output logic [15:0]   stat_wait_cycles,
  output logic [7:0]    stat_timeouts
`endif
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_REL   = 3'd5;
  logic [2:0]    r_state;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic [DW-1:0] r_sum;
  logic [DW-1:0] r_old;
  logic          r_rmw;
  logic          r_abort;
  logic [TW-1:0] r_wait;
  logic [1:0]    r_rd;
  logic [TW-1:0] w_wait_nx;
  logic          w_timeout;
  logic          w_rd_last;
  assign w_wait_nx = r_wait + 1'b1;
  assign w_timeout = (TIMEOUT != 0) && (w_wait_nx == TW'(TIMEOUT));
  assign w_rd_last = r_rd == 2'(RD_LAT - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_sum   <= '0;
      r_old   <= '0;
      r_rmw   <= 1'b0;
      r_abort <= 1'b0;
      r_wait  <= '0;
      r_rd    <= '0;
    end else
      case (r_state)
        S_IDLE:
          if (cmd_valid) begin
            r_addr  <= cmd_addr;
            r_data  <= cmd_data;
            r_rmw   <= cmd_rmw;
            r_abort <= 1'b0;
            r_state <= S_REQ;
          end
        S_REQ: r_state <= S_CHECK;
        S_CHECK:
          if (!stall_in) begin
            r_rd    <= '0;
            r_state <= r_rmw ? S_READ : S_WRITE;
          end else begin
            r_wait <= w_wait_nx;
            if (w_timeout) begin
              r_abort <= 1'b1;
              r_state <= S_REL;
            end
          end
        // mem_addr has been stable since accept, so mem_q is valid by the last READ cycle
        S_READ:
          if (w_rd_last) begin
            r_old   <= mem_q;
            r_sum   <= mem_q + r_data;
            r_state <= S_WRITE;
          end else
            r_rd <= r_rd + 2'd1;
        S_WRITE: r_state <= S_REL;
        default: begin
          r_wait  <= '0;
          r_state <= S_IDLE;
        end
      endcase
  assign cmd_ready = r_state == S_IDLE;
  assign need_lock = (r_state == S_REQ) || (r_state == S_CHECK) || (r_state == S_READ) || (r_state == S_WRITE);
  assign mem_wren  = r_state == S_WRITE;
  assign mem_addr  = r_addr;
  assign mem_data  = r_rmw ? r_sum : r_data;
  assign old_val   = r_old;
  assign done      = (r_state == S_REL) && !r_abort;
  assign err       = (r_state == S_REL) && r_abort;
`ifdef LOCK_STATS_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      stat_grants      <= '0;
      stat_wait_cycles <= '0;
      stat_timeouts    <= '0;
    end else begin
      if (done && stat_grants != '1) stat_grants <= stat_grants + 1'b1;
      if (r_state == S_CHECK && stall_in && stat_wait_cycles != '1) stat_wait_cycles <= stat_wait_cycles + 1'b1;
      if (err && stat_timeouts != '1) stat_timeouts <= stat_timeouts + 1'b1;
    end
`endif
endmodule

// File: tb/tb_lock_mem_requester.sv
// tb_lock_mem_requester: directed tests for lock_mem_requester; a second instance with TIMEOUT=4 covers the abort path.
module tb_lock_mem_requester;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic        cmd_valid = 1'b0, cmd_rmw = 1'b0, stall_in = 1'b0;
  logic [5:0]  cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic        cmd_ready, done, err, need_lock, mem_wren;
  logic [5:0]  mem_addr;
  logic [31:0] mem_data, old_val;
  logic [31:0] mem_q = '0;
  logic        cmd_valid_t = 1'b0, stall_t = 1'b0;
  logic        cmd_ready_t, done_t, err_t, need_lock_t, wren_t;
  logic [5:0]  mem_addr_t;
  logic [31:0] mem_data_t, old_val_t;
  logic [31:0] mem_q_t = '0;
`ifdef LOCK_STATS_EN
  logic [15:0] stat_grants, stat_wait_cycles, stat_grants_t, stat_wait_cycles_t;
  logic [7:0]  stat_timeouts, stat_timeouts_t;
`endif
  logic [31:0] mem [64];
  logic        ld_en = 1'b0;
  logic [5:0]  ld_a = '0;
  logic [31:0] ld_d = '0;
  int wren_cnt = 0, wren_t_cnt = 0;
  int pass_cnt = 0, tot_cnt = 0;
  logic [4:0] fl, fl_t;
  assign fl   = {need_lock, mem_wren, done, err, cmd_ready};
  assign fl_t = {need_lock_t, wren_t, done_t, err_t, cmd_ready_t};

  lock_mem_requester #(.AW(6), .DW(32), .RD_LAT(1), .TIMEOUT(0), .TW(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_rmw(cmd_rmw), .done(done), .err(err), .old_val(old_val),
    .need_lock(need_lock), .stall_in(stall_in), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_wren(mem_wren), .mem_q(mem_q)
`ifdef LOCK_STATS_EN
    , .stat_grants(stat_grants), .stat_wait_cycles(stat_wait_cycles), .stat_timeouts(stat_timeouts)
`endif
  );

  lock_mem_requester #(.AW(6), .DW(32), .RD_LAT(1), .TIMEOUT(4), .TW(8)) dut_to (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_t), .cmd_ready(cmd_ready_t), .cmd_addr(6'd1),
    .cmd_data(32'h2), .cmd_rmw(1'b0), .done(done_t), .err(err_t), .old_val(old_val_t),
    .need_lock(need_lock_t), .stall_in(stall_t), .mem_addr(mem_addr_t), .mem_data(mem_data_t),
    .mem_wren(wren_t), .mem_q(mem_q_t)
`ifdef LOCK_STATS_EN
    , .stat_grants(stat_grants_t), .stat_wait_cycles(stat_wait_cycles_t), .stat_timeouts(stat_timeouts_t)
`endif
  );

  // One-cycle registered-read memory model behind the main instance
  always @(posedge clk) begin
    if (ld_en) mem[ld_a] <= ld_d;
    else if (mem_wren) mem[mem_addr] <= mem_data;
    mem_q <= mem[mem_addr];
    if (mem_wren) wren_cnt <= wren_cnt + 1;
    if (wren_t) wren_t_cnt <= wren_t_cnt + 1;
  end

  task automatic load(input logic [5:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_a = a; ld_d = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic issue(input logic [5:0] a, input logic [31:0] d, input logic r);
    cmd_valid = 1'b1; cmd_addr = a; cmd_data = d; cmd_rmw = r;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    tot_cnt++; if (fl !== 5'b00001) $display("FAIL reset_flags got %b exp %b", fl, 5'b00001); else pass_cnt++;
    tot_cnt++; if (fl_t !== 5'b00001) $display("FAIL reset_flags_t got %b exp %b", fl_t, 5'b00001); else pass_cnt++;
    tot_cnt++; if ({mem_addr, mem_data, old_val} !== 70'd0) $display("FAIL reset_regs got %h/%h/%h exp 0", mem_addr, mem_data, old_val); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    tot_cnt++; if (fl !== 5'b00001) $display("FAIL reset_release got %b exp %b", fl, 5'b00001); else pass_cnt++;
  endtask

  task automatic test_contention();
    stall_in = 1'b1;
    issue(6'd7, 32'hA5A5_0001, 1'b0);
    tot_cnt++; if (fl !== 5'b10000) $display("FAIL cont_req got %b exp %b", fl, 5'b10000); else pass_cnt++;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      tot_cnt++; if (fl !== 5'b10000) $display("FAIL cont_wait%0d got %b exp %b", i, fl, 5'b10000); else pass_cnt++;
    end
    stall_in = 1'b0;
    @(negedge clk);
    tot_cnt++; if (fl !== 5'b11000) $display("FAIL cont_write got %b exp %b", fl, 5'b11000); else pass_cnt++;
    tot_cnt++; if ({mem_addr, mem_data} !== {6'd7, 32'hA5A5_0001}) $display("FAIL cont_wdata got %h/%h exp 07/a5a50001", mem_addr, mem_data); else pass_cnt++;
    stall_in = 1'b1;
    @(negedge clk);
    tot_cnt++; if (fl !== 5'b00100) $display("FAIL cont_done got %b exp %b", fl, 5'b00100); else pass_cnt++;
    tot_cnt++; if (mem[7] !== 32'hA5A5_0001 || wren_cnt !== 1) $display("FAIL cont_mem got %h/%0d exp a5a50001/1", mem[7], wren_cnt); else pass_cnt++;
    stall_in = 1'b0;
    @(negedge clk);
    tot_cnt++; if (fl !== 5'b00001) $display("FAIL cont_idle got %b exp %b", fl, 5'b00001); else pass_cnt++;
`ifdef LOCK_STATS_EN
    tot_cnt++; if (stat_wait_cycles !== 16'd6) $display("FAIL stat_wait got %0d exp 6", stat_wait_cycles); else pass_cnt++;
    tot_cnt++; if (stat_grants !== 16'd1) $display("FAIL stat_grants got %0d exp 1", stat_grants); else pass_cnt++;
`endif
  endtask

  task automatic test_store();
    logic [4:0] exp_f [5] = '{5'b10000, 5'b10000, 5'b11000, 5'b00100, 5'b00001};
    issue(6'd5, 32'hDEAD_BEEF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      tot_cnt++; if (fl !== exp_f[i]) $display("FAIL store_c%0d got %b exp %b", i + 1, fl, exp_f[i]); else pass_cnt++;
      if (i == 2) begin
        tot_cnt++; if ({mem_addr, mem_data} !== {6'd5, 32'hDEAD_BEEF}) $display("FAIL store_wdata got %h/%h exp 05/deadbeef", mem_addr, mem_data); else pass_cnt++;
      end
    end
    tot_cnt++; if (mem[5] !== 32'hDEAD_BEEF || wren_cnt !== 2) $display("FAIL store_mem got %h/%0d exp deadbeef/2", mem[5], wren_cnt); else pass_cnt++;
  endtask

  task automatic test_rmw();
    logic [4:0] exp_f [6] = '{5'b10000, 5'b10000, 5'b10000, 5'b11000, 5'b00100, 5'b00001};
    load(6'd3, 32'h10);
    issue(6'd3, 32'h5, 1'b1);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      tot_cnt++; if (fl !== exp_f[i]) $display("FAIL rmw_c%0d got %b exp %b", i + 1, fl, exp_f[i]); else pass_cnt++;
      if (i == 3) begin
        tot_cnt++; if ({mem_data, old_val} !== {32'h15, 32'h10}) $display("FAIL rmw_vals got %h/%h exp 15/10", mem_data, old_val); else pass_cnt++;
      end
    end
    tot_cnt++; if (mem[3] !== 32'h15) $display("FAIL rmw_mem got %h exp 15", mem[3]); else pass_cnt++;
  endtask

  task automatic test_timeout();
    logic [4:0] exp_f [7] = '{5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b00010, 5'b00001};
    stall_t = 1'b1;
    cmd_valid_t = 1'b1;
    @(negedge clk);
    cmd_valid_t = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      tot_cnt++; if (fl_t !== exp_f[i]) $display("FAIL tmo_c%0d got %b exp %b", i + 1, fl_t, exp_f[i]); else pass_cnt++;
    end
    tot_cnt++; if (wren_t_cnt !== 0) $display("FAIL tmo_nowrite got %0d exp 0", wren_t_cnt); else pass_cnt++;
`ifdef LOCK_STATS_EN
    tot_cnt++; if ({stat_timeouts_t, stat_wait_cycles_t, stat_grants_t} !== {8'd1, 16'd4, 16'd0}) $display("FAIL tmo_stats got %0d/%0d/%0d exp 1/4/0", stat_timeouts_t, stat_wait_cycles_t, stat_grants_t); else pass_cnt++;
`endif
    stall_t = 1'b0;
  endtask

  task automatic test_reset_mid();
    int w0;
    load(6'd9, 32'h100);
    w0 = wren_cnt;
    issue(6'd9, 32'h1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    tot_cnt++; if (fl !== 5'b10000) $display("FAIL rmid_read got %b exp %b", fl, 5'b10000); else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    tot_cnt++; if (fl !== 5'b00001) $display("FAIL rmid_async got %b exp %b", fl, 5'b00001); else pass_cnt++;
    tot_cnt++; if ({mem_addr, old_val} !== 38'd0) $display("FAIL rmid_regs got %h/%h exp 0", mem_addr, old_val); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tot_cnt++; if (fl !== 5'b00001) $display("FAIL rmid_idle got %b exp %b", fl, 5'b00001); else pass_cnt++;
    tot_cnt++; if (mem[9] !== 32'h100 || wren_cnt !== w0) $display("FAIL rmid_nowrite got %h/%0d exp 100/%0d", mem[9], wren_cnt, w0); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_f [10] = '{5'b10000, 5'b10000, 5'b10000, 5'b11000, 5'b00100,
                               5'b00001, 5'b10000, 5'b10000, 5'b11000, 5'b00100};
    load(6'd0, 32'hFFFF_FFFF);
    cmd_valid = 1'b1; cmd_addr = 6'd0; cmd_data = 32'h1; cmd_rmw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tot_cnt++; if (fl !== exp_f[i]) $display("FAIL b2b_c%0d got %b exp %b", i + 1, fl, exp_f[i]); else pass_cnt++;
      if (i == 3) begin
        tot_cnt++; if ({mem_data, old_val} !== {32'h0, 32'hFFFF_FFFF}) $display("FAIL b2b_wrap got %h/%h exp 0/ffffffff", mem_data, old_val); else pass_cnt++;
      end
      if (i == 4) begin cmd_addr = 6'd2; cmd_data = 32'h1234; cmd_rmw = 1'b0; end
      if (i == 6) cmd_valid = 1'b0;
      if (i == 8) begin
        tot_cnt++; if ({mem_addr, mem_data} !== {6'd2, 32'h1234}) $display("FAIL b2b_wdata got %h/%h exp 02/1234", mem_addr, mem_data); else pass_cnt++;
      end
    end
    tot_cnt++; if (mem[0] !== 32'h0 || mem[2] !== 32'h1234) $display("FAIL b2b_mem got %h/%h exp 0/1234", mem[0], mem[2]); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_contention();
    test_store();
    test_rmw();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
